alu_control_pipe: RTL and testbench

Registered, handshaked successor to the combinational ALU-control decoder. It accepts an (ops, func) pair on a valid/ready interface, decodes it to an ALU operation code, and presents the result on a valid/ready output. Multiply-class operations hold the block for a parametrised number of cycles. It sits between the decode stage and the ALU in the pipelined datapath and is the point where multi-cycle ALU stalls originate.

---
 rtl/alu_control_pipe_if.sv | 30 +++
 rtl/alu_control_pipe.sv | 132 +++++++++++++
 tb/tb_alu_control_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_pipe_if.sv
// alu_control_pipe_if: request/result handshake bundle for alu_control_pipe.
// The master side (decode stage) drives the request and out_ready; the slave
// side (the ALU-control block) answers with in_ready, the decoded result and
// its status flags.
interface alu_control_pipe_if #(
    parameter int OPS_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [OPS_W-1:0]   ops;
    logic [FUNC_W-1:0]  func;
    logic               out_valid;
    logic               out_ready;
    logic [ALUOP_W-1:0] out_aluop;
    logic               out_err;
    logic               busy;
    logic               trap;

    modport master (
        output in_valid, ops, func, out_ready,
        input  in_ready, out_valid, out_aluop, out_err, busy, trap
    );

    modport slave (
        input  in_valid, ops, func, out_ready,
        output in_ready, out_valid, out_aluop, out_err, busy, trap
    );
endinterface

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered, handshaked ALU-control decoder.
// Decodes an (ops, func) pair into an ALU operation code. Multiply-class codes
// (ALU_MUL) hold the block in WAIT for MUL_LAT cycles before the result shows.
// Optional feature: define ALU_CTRL_ILLEGAL_TRAP_EN to make an accepted illegal
// decode raise a sticky trap that blocks all further requests until rst.
module alu_control_pipe #(
    parameter int OPS_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 3,
    parameter int MUL_LAT = 4,
    parameter int ALU_ADD = 0,
    parameter int ALU_SUB = 1,
    parameter int ALU_MUL = 7
) (
    input logic              clk,
    input logic              rst,
    alu_control_pipe_if.slave bus
);
    // MUL_LAT tops out at 255, so the down-counter never needs more than 8 bits.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Returns {illegal, code}; an illegal decode carries ALU_ADD as its code.
    function automatic logic [ALUOP_W:0] decode(input logic [OPS_W-1:0]  op,
                                                input logic [FUNC_W-1:0] fn);
        logic [ALUOP_W:0] r;
        r = {1'b1, ALUOP_W'(ALU_ADD)};
        if (op == OPS_W'(1)) begin
            if ((fn >> ALUOP_W) == '0)
                r = {1'b0, fn[ALUOP_W-1:0]};
        end else if (op == OPS_W'(2)) begin
            r = {1'b0, ALUOP_W'(ALU_ADD)};
        end else if (op == OPS_W'(4)) begin
            r = {1'b0, ALUOP_W'(ALU_SUB)};
        end
        return r;
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ALUOP_W-1:0] aluop_p1;
    logic               err_p1;
    logic               trap_q;

    logic [ALUOP_W:0]   dec;
    logic [ALUOP_W-1:0] dec_code;
    logic               dec_err;
    logic               dec_mul;
    logic               accept;

    assign dec      = decode(bus.ops, bus.func);
    assign dec_err  = dec[ALUOP_W];
    assign dec_code = dec[ALUOP_W-1:0];
    assign dec_mul  = !dec_err && (dec_code == ALUOP_W'(ALU_MUL));

    // A result slot frees up either when empty or when the consumer takes it
    // this very cycle; that keeps one op per clock with no bubble.
    assign bus.in_ready = ((state == IDLE) || ((state == OUT) && bus.out_ready)) && !trap_q;
    assign accept       = bus.in_valid && bus.in_ready;

    // Next-state logic: accept routes to WAIT (multiply) or OUT; WAIT counts down.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, OUT: begin
                if (accept) begin
                    if (dec_mul) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(MUL_LAT - 2);
                    end else begin
                        state_nxt = OUT;
                    end
                end else if ((state == OUT) && bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0)
                    state_nxt = OUT;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // --- stage p1: decoded result captured at the accept edge ---
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluop_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            aluop_p1 <= dec_code;
            err_p1   <= dec_err;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    // Sticky trap: the first accepted illegal decode locks the input side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trap_q <= 1'b0;
        else if (accept && dec_err)
            trap_q <= 1'b1;
    end
`else
    assign trap_q = 1'b0;
`endif

    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state == WAIT);
    assign bus.out_aluop = aluop_p1;
    assign bus.out_err   = err_p1;
    assign bus.trap      = trap_q;
endmodule

// File: tb/tb_alu_control_pipe.sv
// tb_alu_control_pipe: randomized and directed bench for alu_control_pipe.
// Two instances share the clock: dut0 with default parameters and dut1 with
// ALUOP_W=4, FUNC_W=5, MUL_LAT=2. A transaction-level model predicts every
// output from the decode rules and the accept/consume timing.
module tb_alu_control_pipe;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_control_pipe_if #(.OPS_W(3), .FUNC_W(4), .ALUOP_W(3)) b0 ();
    alu_control_pipe_if #(.OPS_W(3), .FUNC_W(5), .ALUOP_W(4)) b1 ();

    alu_control_pipe dut0 (.clk(clk), .rst(rst), .bus(b0));
    alu_control_pipe #(.FUNC_W(5), .ALUOP_W(4), .MUL_LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int errs   = 0;
    int checks = 0;

    // per-instance constants
    int lat_of[2] = '{4, 2};
    int aw_of[2]  = '{3, 4};

    // held inputs per instance
    bit iv[2];
    int iop[2];
    int ifn[2];
    bit ior[2];

    // model: at most one result in flight; it becomes visible at cycle m_rdy
    bit m_have[2];
    int m_code[2];
    bit m_err[2];
    int m_rdy[2];
    bit m_trap[2];
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input int d, input int o, input int f,
                                       output int code, output bit err);
        code = 0;
        err  = 1'b0;
        if (o == 1) begin
            if (f < (1 << aw_of[d])) code = f;
            else err = 1'b1;
        end else if (o == 2) code = 0;
        else if (o == 4) code = 1;
        else err = 1'b1;
    endfunction

    function automatic bit exp_valid(input int d);
        return m_have[d] && (cyc >= m_rdy[d]);
    endfunction

    function automatic bit exp_busy(input int d);
        return m_have[d] && (cyc < m_rdy[d]);
    endfunction

    function automatic bit exp_inrdy(input int d);
        return !m_trap[d] && (!m_have[d] || (exp_valid(d) && ior[d]));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_have[d] = 1'b0;
            m_trap[d] = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        b0.in_valid  = iv[0];
        b0.ops       = 3'(iop[0]);
        b0.func      = 4'(ifn[0]);
        b0.out_ready = ior[0];
        b1.in_valid  = iv[1];
        b1.ops       = 3'(iop[1]);
        b1.func      = 5'(ifn[1]);
        b1.out_ready = ior[1];
    endtask

    task automatic sample(input int d, output logic [31:0] ov, output logic [31:0] ob,
                          output logic [31:0] oal, output logic [31:0] oer,
                          output logic [31:0] otr, output logic [31:0] oir);
        if (d == 0) begin
            ov = 32'(b0.out_valid); ob = 32'(b0.busy); oal = 32'(b0.out_aluop);
            oer = 32'(b0.out_err); otr = 32'(b0.trap); oir = 32'(b0.in_ready);
        end else begin
            ov = 32'(b1.out_valid); ob = 32'(b1.busy); oal = 32'(b1.out_aluop);
            oer = 32'(b1.out_err); otr = 32'(b1.trap); oir = 32'(b1.in_ready);
        end
    endtask

    task automatic check_dut(input int d);
        logic [31:0] ov, ob, oal, oer, otr, oir;
        sample(d, ov, ob, oal, oer, otr, oir);
        chk($sformatf("d%0d out_valid c%0d", d, cyc), ov, 32'(exp_valid(d)));
        chk($sformatf("d%0d busy c%0d", d, cyc), ob, 32'(exp_busy(d)));
        chk($sformatf("d%0d trap c%0d", d, cyc), otr, 32'(m_trap[d]));
        chk($sformatf("d%0d in_ready c%0d", d, cyc), oir, 32'(exp_inrdy(d)));
        if (exp_valid(d)) begin
            chk($sformatf("d%0d out_aluop c%0d", d, cyc), oal, 32'(m_code[d]));
            chk($sformatf("d%0d out_err c%0d", d, cyc), oer, 32'(m_err[d]));
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] ov, ob, oal, oer, otr, oir;
            sample(d, ov, ob, oal, oer, otr, oir);
            chk($sformatf("%s d%0d out_valid", tag, d), ov, 0);
            chk($sformatf("%s d%0d busy", tag, d), ob, 0);
            chk($sformatf("%s d%0d out_aluop", tag, d), oal, 0);
            chk($sformatf("%s d%0d out_err", tag, d), oer, 0);
            chk($sformatf("%s d%0d trap", tag, d), otr, 0);
        end
    endtask

    // One clock: called at a falling edge, applies inputs for instance d,
    // checks both instances, then advances the model across the rising edge.
    task automatic tick(input int d, input bit v, input int o, input int f, input bit ordy);
        bit acc[2];
        bit con[2];
        iv[d]  = v;
        iop[d] = o;
        ifn[d] = f;
        ior[d] = ordy;
        drive_inputs();
        #1;
        check_dut(0);
        check_dut(1);
        for (int k = 0; k < 2; k++) begin
            acc[k] = iv[k] && exp_inrdy(k);
            con[k] = exp_valid(k) && ior[k];
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int code;
            bit err;
            if (con[k]) m_have[k] = 1'b0;
            if (acc[k]) begin
                ref_decode(k, iop[k], ifn[k], code, err);
                m_have[k] = 1'b1;
                m_code[k] = code;
                m_err[k]  = err;
                // a result observed at edge t+lat is on the outputs from cycle t+lat-1
                m_rdy[k]  = cyc + ((!err && code == 7) ? lat_of[k] : 1) - 1;
                if (err && TRAP_EN) m_trap[k] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) tick(d, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; iop[d] = 0; ifn[d] = 0; ior[d] = 1'b1;
        end
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");
        chk("reset d0 in_ready", 32'(b0.in_ready), 1);
        chk("reset d1 in_ready", 32'(b1.in_ready), 1);

        // back-to-back single-cycle ops
        tick(0, 1'b1, 1, 6, 1'b1);
        tick(0, 1'b1, 2, 6, 1'b1);
        tick(0, 1'b1, 4, 3, 1'b1);
        idle(0, 2);

        // multiply with MUL_LAT=4
        tick(0, 1'b1, 1, 7, 1'b1);
        for (int i = 0; i < 4; i++) tick(0, 1'b1, 2, 0, 1'b1);
        idle(0, 2);

        // backpressure: result held 5 cycles with a request waiting
        tick(0, 1'b1, 1, 5, 1'b0);
        for (int i = 0; i < 5; i++) tick(0, 1'b1, 4, 0, 1'b0);
        tick(0, 1'b1, 4, 0, 1'b1);
        idle(0, 2);

        // randomized legal traffic on both instances
        for (int i = 0; i < 200; i++) begin
            int sel = $urandom_range(2);
            tick(0, 1'($urandom_range(1)), (sel == 0) ? 1 : (sel == 1) ? 2 : 4,
                 $urandom_range(7), ($urandom_range(3) != 0));
        end
        idle(0, 6);
        for (int i = 0; i < 80; i++) begin
            int sel = $urandom_range(2);
            tick(1, 1'($urandom_range(1)), (sel == 0) ? 1 : (sel == 1) ? 2 : 4,
                 $urandom_range(15), ($urandom_range(3) != 0));
        end
        idle(1, 4);

        // illegal decodes: bad class, then out-of-range func
        tick(0, 1'b1, 3, 0, 1'b1);
        tick(0, 1'b1, 1, 9, 1'b1);
        idle(0, 3);

        do_reset();

        // asynchronous reset while a multiply is in WAIT
        tick(0, 1'b1, 1, 7, 1'b1);
        tick(0, 1'b0, 0, 0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("async rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(0, 5);

        // wider configuration: func 15 legal, multiply at t+2, func 16 illegal
        tick(1, 1'b1, 1, 15, 1'b1);
        idle(1, 1);
        tick(1, 1'b1, 1, 7, 1'b1);
        idle(1, 3);
        tick(1, 1'b1, 1, 16, 1'b1);
        tick(1, 1'b1, 1, 3, 1'b1);
        idle(1, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
